// File: rtl/ptr_sync_pkg.sv
// ----------------------------------------------------------------------------
// ptr_sync_pkg
//   Shared types and helpers for the async-FIFO pointer crossing.
//   - sync_mode_e    : which FIFO side the receiver serves (write -> full,
//                      read -> empty)
//   - MIN/MAX_SYNC_STAGES : legal synchroniser depth range
//   - g2b()          : Gray to binary, works on any width up to 32 bits
//                      (zero-extend the input, truncate the result)
//   - gray_step_ok() : true when two Gray codes differ in at most one bit
// ----------------------------------------------------------------------------
package ptr_sync_pkg;

  typedef enum logic {
    SYNC_WR_SIDE = 1'b0,
    SYNC_RD_SIDE = 1'b1
  } sync_mode_e;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

  // Zero-extended upper bits stay zero through the XOR ripple, so a narrow
  // pointer converts correctly in the low bits.
  function automatic logic [31:0] g2b(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic gray_step_ok(input logic [31:0] a, input logic [31:0] b);
    return ($countones(a ^ b) <= 1);
  endfunction

endpackage

// File: rtl/sync_dff_n.sv
// ----------------------------------------------------------------------------
// sync_dff_n
//   Multi-flop synchroniser chain with async active-high reset to zero.
//   The register array is named cdc_sync_ff so CDC tooling can recognise the
//   chain by name and keep its first stage free of logic.
// Ports
//   clk  in  1      destination-domain clock
//   rst  in  1      async, active-high reset
//   d    in  WIDTH  asynchronous input (must be Gray / single-bit changing)
//   q    out WIDTH  last stage of the chain
// ----------------------------------------------------------------------------
module sync_dff_n #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cdc_sync_ff [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        cdc_sync_ff[i] <= '0;
      end
    end else begin
      cdc_sync_ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        cdc_sync_ff[i] <= cdc_sync_ff[i-1];
      end
    end
  end

  assign q = cdc_sync_ff[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_rx.sv
// ----------------------------------------------------------------------------
// gray_ptr_sync_rx
//   Receive side of an async-FIFO pointer crossing. Synchronises the remote
//   Gray pointer, converts it to binary, and derives fill level plus full
//   (MODE 0, write side) or empty (MODE 1, read side) against the local
//   pointer. Sticky error flags report multi-bit Gray steps and levels above
//   the FIFO depth.
// Parameters
//   PTR_WIDTH    pointer width incl. wrap bit; depth = 2**(PTR_WIDTH-1)
//   SYNC_STAGES  synchroniser depth, 2..4
//   MODE         0 = write side (flag_out = full), 1 = read side (empty)
// Ports
//   clk_in            in   1          local clock
//   reset_in          in   1          async, active-high reset
//   gray_ptr_in       in   PTR_WIDTH  remote Gray pointer
//   local_bin_ptr_in  in   PTR_WIDTH  local binary pointer
//   err_clear_in      in   1          clears err_out (new errors win)
//   binary_ptr_out    out  PTR_WIDTH  synchronised remote pointer, binary
//   ptr_changed_out   out  1          pulse when binary_ptr_out changes
//   level_out         out  PTR_WIDTH  occupancy seen from this side
//   flag_out          out  1          full (MODE 0) / empty (MODE 1)
//   err_out           out  2          [0] Gray multi-bit step, [1] level > depth
// ----------------------------------------------------------------------------
module gray_ptr_sync_rx
  import ptr_sync_pkg::*;
#(
  parameter int PTR_WIDTH   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [PTR_WIDTH-1:0] gray_ptr_in,
  input  logic [PTR_WIDTH-1:0] local_bin_ptr_in,
  input  logic                 err_clear_in,
  output logic [PTR_WIDTH-1:0] binary_ptr_out,
  output logic                 ptr_changed_out,
  output logic [PTR_WIDTH-1:0] level_out,
  output logic                 flag_out,
  output logic [1:0]           err_out
);

  localparam int MSB = PTR_WIDTH - 1;
  localparam sync_mode_e SIDE = (MODE == 0) ? SYNC_WR_SIDE : SYNC_RD_SIDE;
  localparam logic [PTR_WIDTH-1:0] DEPTH = {1'b1, {(PTR_WIDTH-1){1'b0}}};

  generate
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
      $error("gray_ptr_sync_rx: SYNC_STAGES=%0d outside %0d..%0d",
             SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("gray_ptr_sync_rx: MODE=%0d must be 0 or 1", MODE);
    end
    if (PTR_WIDTH < 2 || PTR_WIDTH > 32) begin : g_bad_width
      $error("gray_ptr_sync_rx: PTR_WIDTH=%0d must be 2..32", PTR_WIDTH);
    end
  endgenerate

  logic [MSB:0]         sync_gray;
  logic [MSB:0]         g_q;
  logic [MSB:0]         bin_next;
  logic [SYNC_STAGES:0] prime_sr;
  logic                 primed;
  logic                 step_err;
  logic                 range_err;

  sync_dff_n #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk_in),
    .rst (reset_in),
    .d   (gray_ptr_in),
    .q   (sync_gray)
  );

  assign bin_next = PTR_WIDTH'(g2b(32'(sync_gray)));

  // The step check compares sync_gray against g_q. Right after reset g_q holds
  // the reset zero rather than a real sample, and the first real sample may be
  // any distance from zero. primed rises only once g_q has captured a sample
  // taken after release, i.e. SYNC_STAGES+1 edges after release.
  assign primed   = prime_sr[SYNC_STAGES];
  assign step_err = primed && !gray_step_ok(32'(sync_gray), 32'(g_q));

  always_comb begin
    level_out = '0;
    flag_out  = 1'b0;
    if (SIDE == SYNC_WR_SIDE) begin
      level_out = local_bin_ptr_in - binary_ptr_out;
      flag_out  = (local_bin_ptr_in[MSB] != binary_ptr_out[MSB]) &&
                  (local_bin_ptr_in[MSB-1:0] == binary_ptr_out[MSB-1:0]);
    end else begin
      level_out = binary_ptr_out - local_bin_ptr_in;
      flag_out  = (binary_ptr_out == local_bin_ptr_in);
    end
  end

  assign range_err = (level_out > DEPTH);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      g_q             <= '0;
      binary_ptr_out  <= '0;
      ptr_changed_out <= 1'b0;
      prime_sr        <= '0;
      err_out         <= '0;
    end else begin
      g_q             <= sync_gray;
      binary_ptr_out  <= bin_next;
      ptr_changed_out <= (sync_gray != g_q);
      prime_sr        <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
      // clear first, then OR in new errors so a same-cycle error survives
      err_out[0]      <= (err_out[0] & ~err_clear_in) | step_err;
      err_out[1]      <= (err_out[1] & ~err_clear_in) | range_err;
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync_rx.sv
module tb_gray_ptr_sync_rx;

  logic            clk;
  logic            rst;
  logic [3:0]      gray;
  logic            clr;
  logic [2:0][3:0] loc;
  logic [2:0][3:0] bin_o;
  logic [2:0]      chg_o;
  logic [2:0][3:0] lvl_o;
  logic [2:0]      flag_o;
  logic [2:0][1:0] err_o;

  int n_assert = 0;
  int n_fail   = 0;

  // instance 0: write side, 2 stages; 1: read side, 2 stages; 2: write side, 4 stages
  int SS [3] = '{2, 2, 4};
  int MM [3] = '{0, 1, 0};

  gray_ptr_sync_rx #(.PTR_WIDTH(4), .SYNC_STAGES(2), .MODE(0)) u_wr2 (
    .clk_in(clk), .reset_in(rst), .gray_ptr_in(gray), .local_bin_ptr_in(loc[0]),
    .err_clear_in(clr), .binary_ptr_out(bin_o[0]), .ptr_changed_out(chg_o[0]),
    .level_out(lvl_o[0]), .flag_out(flag_o[0]), .err_out(err_o[0]));

  gray_ptr_sync_rx #(.PTR_WIDTH(4), .SYNC_STAGES(2), .MODE(1)) u_rd2 (
    .clk_in(clk), .reset_in(rst), .gray_ptr_in(gray), .local_bin_ptr_in(loc[1]),
    .err_clear_in(clr), .binary_ptr_out(bin_o[1]), .ptr_changed_out(chg_o[1]),
    .level_out(lvl_o[1]), .flag_out(flag_o[1]), .err_out(err_o[1]));

  gray_ptr_sync_rx #(.PTR_WIDTH(4), .SYNC_STAGES(4), .MODE(0)) u_wr4 (
    .clk_in(clk), .reset_in(rst), .gray_ptr_in(gray), .local_bin_ptr_in(loc[2]),
    .err_clear_in(clr), .binary_ptr_out(bin_o[2]), .ptr_changed_out(chg_o[2]),
    .level_out(lvl_o[2]), .flag_out(flag_o[2]), .err_out(err_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         n;          // clock edges since reset release
  logic [3:0] hist[$];    // hist[i] = Gray value sampled at edge i+1
  bit         e0 [3];
  bit         e1 [3];

  function automatic logic [3:0] gray_of(int b);
    return 4'(b ^ (b >> 1));
  endfunction

  function automatic logic [3:0] bin_of(logic [3:0] g);
    for (int b = 0; b < 16; b++) if (gray_of(b) == g) return 4'(b);
    return 4'h0;
  endfunction

  function automatic logic [3:0] sample(int idx);
    if (idx < 1 || idx > hist.size()) return 4'h0;
    return hist[idx-1];
  endfunction

  // output after edge n reflects the sample taken SYNC_STAGES edges earlier
  function automatic logic [3:0] m_bin(int k);
    return bin_of(sample(n - SS[k]));
  endfunction

  function automatic logic m_chg(int k);
    return sample(n - SS[k]) != sample(n - SS[k] - 1);
  endfunction

  function automatic logic [3:0] m_lvl(int k);
    logic [3:0] r;
    r = m_bin(k);
    if (MM[k] == 0) return 4'(loc[k] - r);
    return 4'(r - loc[k]);
  endfunction

  function automatic logic m_flag(int k);
    if (MM[k] == 0) return m_lvl(k) == 4'd8;
    return m_lvl(k) == 4'd0;
  endfunction

  task automatic chk(string tag, int k, logic [3:0] obs, logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("bin",  k, bin_o[k], m_bin(k));
      chk("chg",  k, {3'b0, chg_o[k]}, {3'b0, m_chg(k)});
      chk("lvl",  k, lvl_o[k], m_lvl(k));
      chk("flag", k, {3'b0, flag_o[k]}, {3'b0, m_flag(k)});
      chk("err",  k, {2'b0, err_o[k]}, {2'b0, e1[k], e0[k]});
    end
  endtask

  task automatic tick();
    bit rng [3];
    for (int k = 0; k < 3; k++) rng[k] = (m_lvl(k) > 4'd8);
    @(posedge clk);
    if (!rst) begin
      hist.push_back(gray);
      n++;
      for (int k = 0; k < 3; k++) begin
        int s;
        bit st;
        s  = SS[k];
        // a jump is only judged once both compared samples are post-reset samples
        st = (n - s - 1 >= 1) && ($countones(sample(n - s) ^ sample(n - s - 1)) > 1);
        e0[k] = (e0[k] && !clr) || st;
        e1[k] = (e1[k] && !clr) || rng[k];
      end
    end
    #1;
    check_all();
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    n = 0;
    hist.delete();
    for (int k = 0; k < 3; k++) begin
      e0[k] = 1'b0;
      e1[k] = 1'b0;
    end
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cur_b;
    rst  = 1'b1;
    gray = 4'b0101;
    clr  = 1'b0;
    loc  = '0;
    loc[0] = 4'd6;
    loc[2] = 4'd6;

    // reset held with a nonzero remote pointer
    assert_reset();
    repeat (3) tick();
    chk("rst_bin", 0, bin_o[0], 4'd0);
    chk("rst_flag_rd", 1, {3'b0, flag_o[1]}, 4'd1);
    rst = 1'b0;
    repeat (6) tick();

    // mid-run reset with Gray 0101 held: first sample jump must not flag
    assert_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick(); tick();
    chk("t6_bin_e2", 0, bin_o[0], 4'd0);
    tick();
    chk("t6_bin_e3", 0, bin_o[0], 4'd6);
    repeat (4) tick();
    chk("t6_err", 0, {2'b0, err_o[0]}, 4'd0);
    chk("t6_err", 2, {2'b0, err_o[2]}, 4'd0);

    // latency 0000 -> 0001
    gray = 4'b0000;
    loc  = '0;
    assert_reset();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    loc[0] = 4'd1;
    loc[2] = 4'd1;
    gray   = 4'b0001;
    tick(); chk("lat_e1", 0, bin_o[0], 4'd0);
    tick(); chk("lat_e2", 0, bin_o[0], 4'd0);
    tick(); chk("lat_e3", 0, bin_o[0], 4'd1);
    chk("lat_chg3", 0, {3'b0, chg_o[0]}, 4'd1);
    tick(); chk("lat_chg4", 0, {3'b0, chg_o[0]}, 4'd0);
    chk("lat4_e4", 2, bin_o[2], 4'd0);
    tick(); chk("lat4_e5", 2, bin_o[2], 4'd1);
    chk("lat4_chg5", 2, {3'b0, chg_o[2]}, 4'd1);

    // full Gray walk with wrap, one step per 2 clocks
    for (int i = 2; i <= 16; i++) begin
      loc[0] = 4'(i);
      loc[2] = 4'(i);
      loc[1] = 4'(i - 3);
      gray   = gray_of(i % 16);
      tick(); tick();
    end
    repeat (6) tick();
    for (int k = 0; k < 3; k++) chk("walk_err", k, {2'b0, err_o[k]}, 4'd0);
    chk("walk_wrap", 0, bin_o[0], 4'd0);

    // bad Gray step, sticky, clear, clear colliding with new error
    loc[0] = 4'd2; loc[2] = 4'd2; loc[1] = 4'd0;
    gray = 4'b0011;
    repeat (6) tick();
    chk("step_err", 0, {2'b0, err_o[0]}, 4'b0001);
    repeat (3) tick();
    chk("step_sticky", 0, {2'b0, err_o[0]}, 4'b0001);
    clr = 1'b1; tick(); clr = 1'b0;
    tick();
    chk("step_clr", 0, {2'b0, err_o[0]}, 4'd0);
    gray = 4'b0000;
    tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("step_setwins", 0, {2'b0, err_o[0]}, 4'b0001);
    repeat (4) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (2) tick();

    // range check and flags
    loc[0] = 4'd8; loc[2] = 4'd8; loc[1] = 4'd0;
    tick();
    chk("full_lvl", 0, lvl_o[0], 4'd8);
    chk("full_flag", 0, {3'b0, flag_o[0]}, 4'd1);
    tick(); tick();
    chk("full_noerr", 0, {2'b0, err_o[0]}, 4'd0);
    loc[0] = 4'd9;
    tick();
    chk("over_lvl", 0, lvl_o[0], 4'd9);
    tick();
    chk("over_err", 0, {2'b0, err_o[0]}, 4'b0010);
    loc[0] = 4'd5; loc[2] = 4'd5;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      gray = gray_of(i);
      tick(); tick();
    end
    repeat (6) tick();
    loc[1] = 4'd5;
    tick();
    chk("empty_flag", 1, {3'b0, flag_o[1]}, 4'd1);
    chk("empty_lvl", 1, lvl_o[1], 4'd0);
    loc[1] = 4'd3;
    tick();
    chk("rd_lvl", 1, lvl_o[1], 4'd2);
    chk("rd_flag", 1, {3'b0, flag_o[1]}, 4'd0);

    // randomized run against the model
    cur_b = 5;
    for (int c = 0; c < 400; c++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r < 6) cur_b = (cur_b + 1) % 16;
      else if (r == 15) cur_b = int'($urandom_range(0, 15));
      gray = gray_of(cur_b);
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 3; k++) loc[k] = 4'($urandom_range(0, 15));
      end
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) begin
        assert_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end
    clr = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
